// File: rtl/main_memory.sv
// main_memory: line-granular backing store answering cache fills/writebacks after REQ_DELAY+RESP_DELAY cycles.
// Define MAIN_MEMORY_RANGE_CHECK_EN to flag (and suppress) accesses at or above SIZE_BYTES.
module main_memory #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128,
    parameter int SIZE_BYTES = 1 << 18,
    parameter int REQ_DELAY  = 5,
    parameter int RESP_DELAY = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_store_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [LINE_WIDTH-1:0] req_data_i,
    output logic                  resp_valid_o,
    output logic [ADDR_WIDTH-1:0] resp_addr_o,
    output logic [LINE_WIDTH-1:0] resp_data_o,
    output logic                  resp_err_o
);
    localparam int LINE_BYTES = LINE_WIDTH / 8;
    localparam int OB = $clog2(LINE_BYTES);
    localparam int SB = $clog2(SIZE_BYTES);
    localparam int LINES = SIZE_BYTES / LINE_BYTES;
    localparam int MAX_D = REQ_DELAY > RESP_DELAY ? REQ_DELAY : RESP_DELAY;
    localparam int CW = $clog2(MAX_D + 1);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic store_q, err, accept, access, finish;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] data_q;
    logic [LINE_WIDTH-1:0] mem [LINES];
    logic [SB-OB-1:0] idx;
    assign req_ready_o = state == IDLE;
    assign accept = req_ready_o && req_valid_i;
    assign access = state == REQ && cnt == CW'(REQ_DELAY - 1);
    assign finish = state == RESP && cnt == CW'(RESP_DELAY - 1);
    assign idx = addr_q[SB-1:OB];
    always_comb begin
        state_nx = accept ? REQ : access ? RESP : finish ? IDLE : state;
        cnt_nx = (state == IDLE || access) ? '0 : cnt + 1'b1;
    end
    // The DONE phase is the registered resp_valid_o pulse, overlapping IDLE so the next accept can follow at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            store_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            resp_valid_o <= 1'b0;
            resp_addr_o <= '0;
            resp_data_o <= '0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            resp_valid_o <= finish;
            if (accept) begin
                store_q <= req_store_i;
                addr_q <= req_addr_i & ~ADDR_WIDTH'(LINE_BYTES - 1);
                data_q <= req_data_i;
            end
            if (access && !store_q) data_q <= err ? '0 : mem[idx];
            if (finish) begin
                resp_addr_o <= addr_q;
                resp_data_o <= data_q;
            end
        end
    end
    always_ff @(posedge clk)
        if (access && store_q && !err && !reset) mem[idx] <= data_q;
`ifdef MAIN_MEMORY_RANGE_CHECK_EN
    logic err_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
            resp_err_o <= 1'b0;
        end else begin
            if (accept) err_q <= |(req_addr_i >> SB);
            if (finish) resp_err_o <= err_q;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
    assign resp_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_main_memory.sv
// tb_main_memory: directed and scoreboard checks of main_memory latency, ordering, reset aborts and address range.
module tb_main_memory;
    logic clk = 1'b0;
    logic reset, req_valid_i, req_ready_o, req_store_i, resp_valid_o, resp_err_o;
    logic [31:0] req_addr_i, resp_addr_o;
    logic [127:0] req_data_i, resp_data_o;
    int checks = 0, errors = 0;
    int lat, rdy_low, pulses;
    logic [127:0] r_data;
    logic [31:0] r_addr;
    logic r_err;
    time acc_t, t1;
    logic [127:0] model [16];
    localparam logic [127:0] A5 = {16{8'hA5}};
    main_memory dut (
        .clk(clk), .reset(reset), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_store_i(req_store_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
        .resp_valid_o(resp_valid_o), .resp_addr_o(resp_addr_o), .resp_data_o(resp_data_o),
        .resp_err_o(resp_err_o)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic op(input logic st, input logic [31:0] a, input logic [127:0] d, input bit hold);
        int k = 0;
        req_store_i = st;
        req_addr_i = a;
        req_data_i = d;
        req_valid_i = 1'b1;
        while (!req_ready_o && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready_o) check("accept_timeout", 0, 1);
        @(posedge clk);
        acc_t = $time;
        @(negedge clk);
        if (!hold) req_valid_i = 1'b0;
        lat = 0;
        rdy_low = 0;
        while (!resp_valid_o && lat < 40) begin
            rdy_low += int'(!req_ready_o);
            @(negedge clk);
            lat++;
        end
        r_data = resp_data_o;
        r_addr = resp_addr_o;
        r_err = resp_err_o;
    endtask
    task automatic watch(input int n);
        pulses = 0;
        repeat (n) begin
            @(negedge clk);
            pulses += int'(resp_valid_o);
        end
    endtask
    task automatic abort_store(input logic [31:0] a, input logic [127:0] d, input int rc);
        req_store_i = 1'b1;
        req_addr_i = a;
        req_data_i = d;
        req_valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid_i = 1'b0;
        repeat (rc) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        watch(15);
        check($sformatf("abort%0d_no_resp", rc), pulses, 0);
        check($sformatf("abort%0d_ready", rc), req_ready_o, 1);
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
    initial begin
        reset = 1'b1;
        req_valid_i = 1'b0;
        req_store_i = 1'b0;
        req_addr_i = '0;
        req_data_i = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_ready", req_ready_o, 1);
        check("rst_valid", resp_valid_o, 0);
        check("rst_addr", resp_addr_o, 0);
        check("rst_data", resp_data_o, 0);
        check("rst_err", resp_err_o, 0);
        rdy_low = 0;
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            pulses += int'(resp_valid_o);
            rdy_low += int'(!req_ready_o);
        end
        check("idle_pulses", pulses, 0);
        check("idle_ready_low", rdy_low, 0);
        op(1'b1, 32'h0000_1000, A5, 1'b0);
        check("st_lat", lat, 10);
        check("st_busy", rdy_low, 10);
        check("st_addr", r_addr, 32'h0000_1000);
        check("st_data", r_data, A5);
        check("st_err", r_err, 0);
        check("st_ready_at_resp", req_ready_o, 1);
        @(negedge clk);
        check("st_pulse_width", resp_valid_o, 0);
        op(1'b0, 32'h0000_100C, '0, 1'b0);
        check("ld_lat", lat, 10);
        check("ld_data", r_data, A5);
        check("ld_addr", r_addr, 32'h0000_1000);
        op(1'b1, 32'h0000_1010, 128'h1111, 1'b1);
        t1 = acc_t;
        check("b2b_busy0", rdy_low, 10);
        op(1'b1, 32'h0000_1010, 128'h1111, 1'b0);
        check("b2b_spacing", 128'((acc_t - t1) / 10), 11);
        check("b2b_busy1", rdy_low, 10);
        check("b2b_lat", lat, 10);
        @(negedge clk);
        reset = 1'b1;
        req_valid_i = 1'b1;
        req_store_i = 1'b1;
        req_addr_i = 32'h3000;
        @(negedge clk);
        reset = 1'b0;
        req_valid_i = 1'b0;
        watch(15);
        check("rst_vs_valid_no_resp", pulses, 0);
        op(1'b1, 32'h0000_2000, 128'h0DD, 1'b0);
        abort_store(32'h0000_2000, 128'h1E1, 3);
        op(1'b0, 32'h0000_2000, '0, 1'b0);
        check("abort3_old_data", r_data, 128'h0DD);
        abort_store(32'h0000_2000, 128'h1E7, 7);
        op(1'b0, 32'h0000_2000, '0, 1'b0);
        check("abort7_new_data", r_data, 128'h1E7);
        op(1'b1, 32'h0000_0000, 128'hC0FFEE, 1'b0);
        op(1'b0, 32'h0004_0000, '0, 1'b0);
        check("oor_lat", lat, 10);
`ifdef MAIN_MEMORY_RANGE_CHECK_EN
        check("oor_err", r_err, 1);
        check("oor_data", r_data, 0);
        op(1'b1, 32'h0004_0000, 128'hBAD, 1'b0);
        check("oor_st_err", r_err, 1);
        op(1'b0, 32'h0000_0000, '0, 1'b0);
        check("oor_st_no_write", r_data, 128'hC0FFEE);
        check("inrange_err", r_err, 0);
`else
        check("alias_err", r_err, 0);
        check("alias_data", r_data, 128'hC0FFEE);
`endif
        for (int i = 0; i < 16; i++) begin
            model[i] = {$urandom, $urandom, $urandom, $urandom};
            op(1'b1, 32'h8000 + 32'(i * 16), model[i], 1'b0);
        end
        for (int n = 0; n < 1000; n++) begin
            int li;
            logic st;
            logic [31:0] a;
            logic [127:0] d;
            li = int'($urandom_range(0, 15));
            st = 1'($urandom_range(0, 1));
            a = 32'h8000 + 32'(li * 16) + 32'($urandom_range(0, 15));
            d = {$urandom, $urandom, $urandom, $urandom};
            op(st, a, d, 1'b0);
            if (st) model[li] = d;
            check($sformatf("rnd%0d_lat", n), lat, 10);
            check($sformatf("rnd%0d_data", n), r_data, model[li]);
            check($sformatf("rnd%0d_addr", n), r_addr, 32'h8000 + 32'(li * 16));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
